// File: rtl/step_cmd_sequencer_if.sv
// Command/step bus of the step sequencer: FIFO read side plus motor-driver outputs.
// master = sequencer, slave = FIFO/driver side (or a testbench).
interface step_cmd_sequencer_if;
    logic        en;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        fifo_rd_en;
    logic        step;
    logic        dir;
    logic        busy;
    logic        done;

    modport master (
        input  en, fifo_empty, fifo_data,
        output fifo_rd_en, step, dir, busy, done
    );

    modport slave (
        output en, fifo_empty, fifo_data,
        input  fifo_rd_en, step, dir, busy, done
    );
endinterface

// File: rtl/step_cmd_sequencer.sv
// Pops step commands from a FIFO and plays them out as step/dir pulse trains.
// Define STEP_SEQ_ABORT_EN to add the abort input (cancels a latched/running command).
module step_cmd_sequencer #(
    parameter int unsigned MIN_HALF_PERIOD = 2
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef STEP_SEQ_ABORT_EN
    input  logic                 abort,
`endif
    step_cmd_sequencer_if.master bus
);

    localparam logic [15:0] MIN_HP = 16'(MIN_HALF_PERIOD);

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_LATCH,
        S_RUN
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [14:0] r_steps;
    logic [15:0] r_phase;
    logic [15:0] r_he;
    logic        r_high;
    logic        r_step;
    logic        r_dir;
    logic        r_done;

    logic        w_abort;
    logic        w_can_pop;
    logic [14:0] w_cmd_n;
    logic [15:0] w_cmd_h;
    logic [15:0] w_he;

`ifdef STEP_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_can_pop = bus.en && !bus.fifo_empty;
    assign w_cmd_n   = bus.fifo_data[30:16];
    assign w_cmd_h   = bus.fifo_data[15:0];
    assign w_he      = (w_cmd_h < MIN_HP) ? MIN_HP : w_cmd_h;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets its default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_can_pop) w_next = S_POP;
            end
            S_POP: begin
                w_next = S_LATCH;
            end
            S_LATCH: begin
                if (w_abort || (w_cmd_n == 15'd0)) w_next = S_IDLE;
                else                                w_next = S_RUN;
            end
            S_RUN: begin
                // r_steps == 0 in RUN is the single done cycle after the last high phase
                if (w_abort)                w_next = S_IDLE;
                else if (r_steps == 15'd0) w_next = w_can_pop ? S_POP : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_steps <= '0;
            r_phase <= '0;
            r_he    <= '0;
            r_high  <= 1'b0;
            r_step  <= 1'b0;
            r_dir   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_LATCH: begin
                    if (!w_abort) begin
                        r_dir   <= bus.fifo_data[31];
                        r_steps <= w_cmd_n;
                        r_he    <= w_he;
                        r_phase <= (w_cmd_n == 15'd0) ? 16'd0 : w_he;
                        r_high  <= 1'b0;
                        r_step  <= 1'b0;
                        if (w_cmd_n == 15'd0) r_done <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_abort) begin
                        r_step  <= 1'b0;
                        r_high  <= 1'b0;
                        r_steps <= '0;
                        r_phase <= '0;
                    end else if (r_steps != 15'd0) begin
                        if (r_phase == 16'd1) begin
                            if (!r_high) begin
                                r_high  <= 1'b1;
                                r_step  <= 1'b1;
                                r_phase <= r_he;
                            end else begin
                                // end of a high phase: one step finished
                                r_high  <= 1'b0;
                                r_step  <= 1'b0;
                                r_steps <= r_steps - 15'd1;
                                if (r_steps == 15'd1) begin
                                    r_done  <= 1'b1;
                                    r_phase <= '0;
                                end else begin
                                    r_phase <= r_he;
                                end
                            end
                        end else begin
                            r_phase <= r_phase - 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.fifo_rd_en = (r_state == S_POP) && !bus.fifo_empty;
    assign bus.step       = r_step;
    assign bus.dir        = r_dir;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = r_done;

endmodule

// File: tb/tb_step_cmd_sequencer.sv
// Directed bench for step_cmd_sequencer: small FIFO model, per-cycle sampling on the falling edge.
// The abort scenario is compiled in only with STEP_SEQ_ABORT_EN.
module tb_step_cmd_sequencer;

    logic clk;
    logic rst;
`ifdef STEP_SEQ_ABORT_EN
    logic abort;
`endif

    step_cmd_sequencer_if bus ();

    step_cmd_sequencer #(.MIN_HALF_PERIOD(2)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef STEP_SEQ_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] q[$];
    int          n_cmp;
    int          n_err;
    logic        s_step, s_dir, s_busy, s_done, s_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        q.push_back(w);
        bus.fifo_empty = 1'b0;
    endtask

    // Sample outputs mid-cycle, then model the FIFO pop just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        s_step = bus.step;
        s_dir  = bus.dir;
        s_busy = bus.busy;
        s_done = bus.done;
        s_rd   = bus.fifo_rd_en;
        @(posedge clk);
        #1;
        if (s_rd && q.size() != 0) begin
            bus.fifo_data  = q.pop_front();
            bus.fifo_empty = (q.size() == 0);
        end
    endtask

    task automatic wait_pop(input string tag, output int waits);
        waits = 0;
        do begin
            cycle();
            waits++;
        end while (!s_rd && waits < 64);
        check({tag, "_pop_seen"}, s_rd, 1'b1);
    endtask

    // Offset 0 = POP cycle, 1 = LATCH, RUN from 2; done expected at 2 + 2*N*He.
    task automatic run_cmd(input string tag, input logic exp_dir, input int n, input int he,
                           input logic old_dir, input bit drop_en, output int waits);
        int   last;
        int   step_err, dir_err, busy_err, done_cnt, done_at, rd_cnt;
        logic e_step, e_dir, e_busy;
        last     = 2 + 2 * n * he;
        step_err = 0; dir_err = 0; busy_err = 0;
        done_cnt = 0; done_at = -1; rd_cnt = 0;
        wait_pop(tag, waits);
        if (!s_rd) return;
        for (int k = 0; k <= last; k++) begin
            if (k > 0) cycle();
            if (drop_en && k == 1) bus.en = 1'b0;
            e_step = (k >= 2 && (k - 2) < 2 * n * he) ? (((k - 2) % (2 * he)) >= he) : 1'b0;
            e_dir  = (k >= 2) ? exp_dir : old_dir;
            e_busy = !(n == 0 && k == last);
            if (s_step !== e_step) step_err++;
            if (s_dir  !== e_dir)  dir_err++;
            if (s_busy !== e_busy) busy_err++;
            if (s_done) begin
                done_cnt++;
                done_at = k;
            end
            if (s_rd) rd_cnt++;
        end
        check({tag, "_step_wave_errs"}, step_err, 0);
        check({tag, "_dir_errs"},       dir_err,  0);
        check({tag, "_busy_errs"},      busy_err, 0);
        check({tag, "_done_count"},     done_cnt, 1);
        check({tag, "_done_offset"},    done_at,  last);
        check({tag, "_pop_count"},      rd_cnt,   1);
    endtask

    initial begin
        int w;
        int rd_cnt, done_cnt;
        n_cmp = 0;
        n_err = 0;
        rst            = 1'b1;
        bus.en         = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = '0;
`ifdef STEP_SEQ_ABORT_EN
        abort = 1'b0;
`endif

        // Reset state
        cycle();
        cycle();
        check("rst_step", s_step, 1'b0);
        check("rst_dir",  s_dir,  1'b0);
        check("rst_busy", s_busy, 1'b0);
        check("rst_done", s_done, 1'b0);
        check("rst_rd",   s_rd,   1'b0);
        rst = 1'b0;
        cycle();
        check("idle_busy_empty", s_busy, 1'b0);

        // Three pulses, dir=1, He=2
        bus.en = 1'b1;
        push(32'h8003_0002);
        run_cmd("cmd_8003_0002", 1'b1, 3, 2, 1'b0, 1'b0, w);
        cycle();
        check("after_cmd1_idle", s_busy, 1'b0);

        // H=0 clamped to MIN_HALF_PERIOD
        push(32'h0002_0000);
        run_cmd("cmd_clamp", 1'b0, 2, 2, 1'b1, 1'b0, w);

        // Back-to-back: second pop in the cycle right after the first done
        push(32'h0001_0003);
        push(32'h8001_0003);
        run_cmd("b2b_first",  1'b0, 1, 3, 1'b0, 1'b0, w);
        run_cmd("b2b_second", 1'b1, 1, 3, 1'b0, 1'b0, w);
        check("b2b_gap_cycles", w, 1);

        // N=0: no pulses, done one cycle after LATCH while back in IDLE
        push(32'h0000_0005);
        run_cmd("cmd_n0", 1'b0, 0, 5, 1'b1, 1'b0, w);

        // en dropped mid-command: command completes, next pop is held off
        push(32'h0001_0002);
        push(32'h0001_0002);
        run_cmd("en_drop", 1'b0, 1, 2, 1'b0, 1'b1, w);
        rd_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (s_rd) rd_cnt++;
        end
        check("en_low_no_pop", rd_cnt, 0);
        check("en_low_idle",   s_busy, 1'b0);
        bus.en = 1'b1;
        run_cmd("en_resume", 1'b0, 1, 2, 1'b0, 1'b0, w);

        // Reset during the second step of 0x0005_0004
        push(32'h0005_0004);
        wait_pop("rst_mid", w);
        repeat (14) cycle();
        check("rst_mid_pre_step", s_step, 1'b1);
        push(32'h8001_0002);
        rst = 1'b1;
        #1;
        check("rst_mid_step", bus.step,       1'b0);
        check("rst_mid_dir",  bus.dir,        1'b0);
        check("rst_mid_busy", bus.busy,       1'b0);
        check("rst_mid_done", bus.done,       1'b0);
        check("rst_mid_rd",   bus.fifo_rd_en, 1'b0);
        rd_cnt   = 0;
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (s_rd)   rd_cnt++;
            if (s_done) done_cnt++;
        end
        check("rst_hold_no_pop",  rd_cnt,   0);
        check("rst_hold_no_done", done_cnt, 0);
        rst = 1'b0;
        run_cmd("after_rst", 1'b1, 1, 2, 1'b0, 1'b0, w);

`ifdef STEP_SEQ_ABORT_EN
        // Abort during RUN: step drops, IDLE, no done, no further pops
        push(32'h0010_0003);
        wait_pop("abort", w);
        repeat (6) cycle();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("abort_pre_step", s_step,   1'b1);
        check("abort_step",     bus.step, 1'b0);
        check("abort_busy",     bus.busy, 1'b0);
        rd_cnt   = 0;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (s_rd)   rd_cnt++;
            if (s_done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_no_pop",  rd_cnt,   0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/step_cmd_sequencer.md
STEP_CMD_SEQUENCER -- requirements
Module: step_cmd_sequencer

Interface
REQ-001 SHALL have parameter MIN_HALF_PERIOD, default 2, minimum step half-period in clocks (range 1..65535).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port en  input  1  sequencer enable; 0 holds the block in IDLE.
REQ-005 SHALL have port fifo_empty  input  1  command FIFO empty flag.
REQ-006 SHALL have port fifo_data  input  32  command FIFO read data, valid the cycle after fifo_rd_en.
REQ-007 SHALL have port fifo_rd_en  output  1  command FIFO pop strobe.
REQ-008 SHALL have port step  output  1  registered step pulse to the motor driver.
REQ-009 SHALL have port dir  output  1  registered direction to the motor driver.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse on completion of each command.

Function
REQ-012 Command word: [31] direction, [30:16] step count N (15 bit), [15:0] half-period H field.
REQ-013 Effective half-period He SHALL be max(H, MIN_HALF_PERIOD), computed at latch time.
REQ-014 FSM states: IDLE, POP, LATCH, RUN; encoding free.
REQ-015 IDLE -> POP when en=1 and fifo_empty=0; otherwise stay in IDLE.
REQ-016 POP: fifo_rd_en=1 for exactly this one cycle; next state LATCH unconditionally.
REQ-017 LATCH: capture fifo_data; dir <= bit 31 on the edge leaving LATCH; load step counter with N and phase counter with He.
REQ-018 LATCH with N=0: no pulses, done=1 in the following cycle, next state IDLE.
REQ-019 RUN: each step = He cycles step=0 followed by He cycles step=1; first step begins with the low phase, giving dir He cycles of setup.
REQ-020 Step counter SHALL decrement at the end of each high phase; after the Nth high phase step returns to 0 and done pulses for one cycle.
REQ-021 After done: if en=1 and fifo_empty=0, next state POP directly (no IDLE cycle); otherwise IDLE.
REQ-022 fifo_rd_en SHALL never assert while fifo_empty=1 or outside POP; at most one pop per command.
REQ-023 en deasserted during POP/LATCH/RUN SHALL NOT abort the current command; it only blocks the next pop.
REQ-024 dir SHALL hold its value between commands and change only at LATCH.
REQ-025 Counters SHALL NOT wrap: phase counter counts He..1, step counter N..1, no underflow past 0.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, fifo_rd_en=0, step=0, dir=0, busy=0, done=0 and clear all counters.
REQ-027 Reset mid-RUN SHALL discard the in-flight command; no done pulse is issued for it.

Configuration
REQ-028 Macro STEP_SEQ_ABORT_EN SHALL, when defined, add input port abort (1 bit).
REQ-029 With STEP_SEQ_ABORT_EN defined: abort=1 in LATCH or RUN forces step=0 and IDLE next cycle, no done pulse; abort=1 in IDLE/POP is ignored.
REQ-030 Without STEP_SEQ_ABORT_EN: no abort port; commands always run to completion.

Verification
REQ-031 FIFO holds 0x8003_0002, MIN_HALF_PERIOD=2 -> one pop, dir=1, 3 pulses each 2 low / 2 high, done 1 cycle after 3rd high phase.
REQ-032 Word 0x0002_0000 -> He=2 (clamped), dir=0, 2 pulses of 2 low / 2 high, done pulses once.
REQ-033 Two words queued (0x0001_0003, 0x8001_0003) -> second pop in cycle after first done, dir flips only at second LATCH.
REQ-034 Word 0x0000_0005 (N=0) -> no step activity, done 1 cycle after LATCH, back to IDLE.
REQ-035 rst pulsed during 2nd step of 0x0005_0004 -> all outputs 0 immediately, no done, next pop only after rst=0 and fifo_empty=0.
REQ-036 STEP_SEQ_ABORT_EN defined, abort during RUN of 0x0010_0003 -> step=0 next cycle, IDLE, no done; fifo_empty=1 -> fifo_rd_en never asserts.
